// File: rtl/alu_pkg.sv
// Types and constants for the execute-stage ALU.
// No logic; types and one helper function.
// No flow control.
package aluPkg;
  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op;

  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } alu_state;

  // True for the ops that go through the iterative shifter.
  function automatic logic is_shift(input alu_op op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction
endpackage

// File: rtl/rysy_pkg.sv
// Core-wide constants shared by the rysyCore pipeline stages.
// No logic; constants only.
// No flow control.
package rysyPkg;
  localparam int REG_LEN = 32;
endpackage

// File: rtl/alu_seq_shift_step.sv
// One combinational step of the iterative shifter: shifts acc by 0..4 bits.
// Latency 0 (pure combinational).
// No flow control; the caller decides when the step is applied.
module alu_shift_step
  import rysyPkg::*;
  import aluPkg::*;
(
  input  logic [REG_LEN-1:0] acc,
  input  logic [2:0]         step,
  input  aluPkg::alu_op      op,
  output logic [REG_LEN-1:0] acc_shifted
);

  // SRA replicates the sign bit; SLL/SRL fill with zeros.
  always_comb begin
    acc_shifted = acc;
    case (op)
      ALU_SLL: acc_shifted = acc << step;
      ALU_SRL: acc_shifted = acc >> step;
      ALU_SRA: acc_shifted = $unsigned($signed(acc) >>> step);
      default: acc_shifted = acc;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Execute-stage ALU: 1-cycle add/sub/logic/compare, iterative shifts of SHIFT_STEP bits/cycle.
// Latency 1 for non-shift ops (and shamt=0), ceil(shamt/SHIFT_STEP)+1 for shifts.
// busy is high while shifting; start is ignored unless idle (busy=0, not in DONE).
module alu_seq
  import rysyPkg::*;
  import aluPkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REG_LEN-1:0] alu_in1,
  input  logic [REG_LEN-1:0] alu_in2,
  input  aluPkg::alu_op      alu_op,
  input  logic               start,
  output logic [REG_LEN-1:0] result,
  output logic               valid,
  output logic               busy
);

  // Only step sizes that a 3-bit step field and a small mux can serve are legal.
  generate
    if (!(SHIFT_STEP == 1 || SHIFT_STEP == 2 || SHIFT_STEP == 4)) begin : g_bad_step
      $error("alu_seq: SHIFT_STEP must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [SHAMT_W-1:0] STEP_MAX = SHAMT_W'(SHIFT_STEP);

  aluPkg::alu_state   state, state_nxt;
  aluPkg::alu_op      op_q;
  logic [REG_LEN-1:0] acc;
  logic [REG_LEN-1:0] acc_shifted;
  logic [SHAMT_W-1:0] remaining;
  logic [SHAMT_W-1:0] shamt_in;
  logic [2:0]         step;
  logic [REG_LEN-1:0] fast_res;
  logic               load_fast;
  logic               load_shift;
  logic               shift_last;

  assign shamt_in = alu_in2[SHAMT_W-1:0];
  assign valid    = (state == ST_DONE);
  assign busy     = (state == ST_SHIFT);

  // Bits to shift this cycle: whatever is left, capped at SHIFT_STEP.
  always_comb begin
    step = STEP_MAX[2:0];
    if (remaining < STEP_MAX) step = remaining[2:0];
  end

  alu_shift_step u_shift_step (
    .acc         (acc),
    .step        (step),
    .op          (op_q),
    .acc_shifted (acc_shifted)
  );

  // Single-cycle datapath; shift ops only reach here with shamt=0, so they pass alu_in1.
  always_comb begin
    fast_res = '0;
    case (alu_op)
      ALU_ADD:  fast_res = alu_in1 + alu_in2;
      ALU_SUB:  fast_res = alu_in1 - alu_in2;
      ALU_SLT:  fast_res = {{(REG_LEN-1){1'b0}}, ($signed(alu_in1) < $signed(alu_in2))};
      ALU_SLTU: fast_res = {{(REG_LEN-1){1'b0}}, (alu_in1 < alu_in2)};
      ALU_XOR:  fast_res = alu_in1 ^ alu_in2;
      ALU_OR:   fast_res = alu_in1 | alu_in2;
      ALU_AND:  fast_res = alu_in1 & alu_in2;
      ALU_SLL,
      ALU_SRL,
      ALU_SRA:  fast_res = alu_in1;
      default:  fast_res = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and datapath load strobes; start is only honoured in IDLE.
  always_comb begin
    state_nxt  = state;
    load_fast  = 1'b0;
    load_shift = 1'b0;
    shift_last = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (is_shift(alu_op) && (shamt_in != '0)) begin
            load_shift = 1'b1;
            state_nxt  = ST_SHIFT;
          end else begin
            load_fast = 1'b1;
            state_nxt = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        if (remaining == SHAMT_W'(step)) begin
          shift_last = 1'b1;
          state_nxt  = ST_DONE;
        end
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Operand latch, shift accumulator/counter and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      acc       <= '0;
      remaining <= '0;
      op_q      <= ALU_ADD;
    end else begin
      if (load_fast) result <= fast_res;
      if (load_shift) begin
        acc       <= alu_in1;
        remaining <= shamt_in;
        op_q      <= alu_op;
      end else if (state == ST_SHIFT) begin
        acc       <= acc_shifted;
        remaining <= remaining - SHAMT_W'(step);
      end
      if (shift_last) result <= acc_shifted;
    end
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Execute-stage ALU of rysyCore, directly downstream of the operand-2 mux.
- Consumes alu_in1 (rs1 data or PC) and alu_in2 (rs2 data or immediate) and produces a registered result with a start/valid handshake.
- Add, sub, logic and compare ops complete in 1 cycle.
- Shifts run iteratively, SHIFT_STEP bits per cycle, to save area over a barrel shifter.
- The control unit stalls the pipeline while busy is high.

Parameters:
- SHIFT_STEP, 1, bits shifted per SHIFT cycle. Legal values are 1, 2 or 4; any other value is an elaboration error.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- alu_in1  input  REG_LEN  operand 1.
- alu_in2  input  REG_LEN  operand 2, from the operand-2 mux.
- alu_op  input  aluPkg::alu_op  operation, sampled with start.
- start  input  1  request. Accepted only when busy=0.
- result  output  REG_LEN  registered result. Held until the next accepted start.
- valid  output  1  one-cycle pulse; result is new in that cycle.
- busy  output  1  high from the cycle after an accepted shift start until valid.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, result=0, valid=0, busy=0, internal counter and operand registers cleared. Reset wins over start in the same cycle.
- States:
  - IDLE: waiting for start.
  - SHIFT: iterating a shift.
  - DONE: one-cycle state that drives valid.
- IDLE, start=1, non-shift op, or shift op with shamt=0:
  - result is computed from the current inputs and registered.
  - Next state is DONE. valid=1 in the following cycle, so latency is 1.
- IDLE, start=1, SLL/SRL/SRA with shamt != 0:
  - shamt = alu_in2[4:0]. alu_in1 is latched into an acc register and shamt into a remaining counter.
  - Next state is SHIFT and busy=1.
- SHIFT, each cycle:
  - step = min(remaining, SHIFT_STEP).
  - acc is shifted by step. SRA fills with acc[REG_LEN-1]; SLL and SRL fill with 0.
  - remaining is decremented by step.
  - When remaining reaches 0 in a cycle, result is loaded from the shifted acc and the next state is DONE.
- DONE: valid=1 and busy=0. Next state is IDLE. A start here is ignored; it is accepted the following cycle.
- Shift latency from start to valid = ceil(shamt/SHIFT_STEP)+1 cycles.
- start while busy=1: ignored. No error flag is raised, and the latched operands are not disturbed.
- Operands are latched at the accepted start. Input changes during SHIFT have no effect.
- Arithmetic:
  - ADD and SUB are modulo 2^REG_LEN. No overflow flag.
  - SLT is a signed compare; SLTU is unsigned. Both produce {31'b0, lt}.
  - XOR, OR, AND are bitwise.
- Undefined alu_op encodings produce result=0 with normal 1-cycle latency.
- Reset mid-shift aborts the shift: state=IDLE, result=0 and no valid pulse.

Decomposition:
- aluPkg (new package, beside alu2Pkg) holds:
  - typedef enum logic [3:0] alu_op {ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND}.
  - localparam SHAMT_W = 5.
  - state typedef alu_state {ST_IDLE, ST_SHIFT, ST_DONE}.
- REG_LEN comes from rysyPkg.
- Sub-module alu_shift_step: a combinational single step that takes acc, step, op and returns the shifted acc.
- The FSM, counter and 1-cycle datapath stay in alu_seq.

Test Plan:
- ADD, 0xFFFF_FFFF + 0x0000_0002 -> result 0x0000_0001, valid exactly 1 cycle after start, busy never asserted.
- SLT vs SLTU, in1=0xFFFF_FFFF, in2=0x1 -> SLT gives 0x1, SLTU gives 0x0.
- SRA, 0x8000_0000 by 31 with SHIFT_STEP=1 -> result 0xFFFF_FFFF, valid 32 cycles after start, busy high for 31 cycles. Repeat with SHIFT_STEP=4 -> valid 9 cycles after start.
- SLL by 0 (in2=0x20, so shamt=0), in1=0x1234_5678 -> result 0x1234_5678 with 1-cycle latency, no SHIFT state.
- start pulsed every cycle during an SRL of 0xF000_0000 by 8 -> extra starts ignored, result 0x00F0_0000, single valid pulse, then the next start is accepted in the cycle after DONE.
- rst asserted mid-shift (SLL by 20, rst at cycle 5) -> next cycle result=0, valid=0, busy=0, state IDLE; no valid appears afterwards without a new start.
